// File: rtl/ddr_512b_enc_gen_pkg.sv
// rtl/ddr_512b_enc_gen_pkg.sv - shared types and constants for the DDR 512b encoder test-pattern path
package ddr_enc_pkg;

  // Generator FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } enc_state_e;

  // Filler carried above the packet counter; repeated LSB-first for wide words
  localparam logic [47:0] FILL_PAT = 48'hBBBB_CCCC_DDDD;

  // Packet counter width, shared with the encoder-side checker
  localparam int PKT_CNT_WD = 16;

endpackage

// File: rtl/ddr_512b_enc_gen_if.sv
// rtl/ddr_512b_enc_gen_if.sv - valid/ready word stream from the pattern generator to the encoder
interface ddr_512b_enc_gen_if #(
  parameter int DATA_WD = 64
);
  logic               enc_vld;
  logic               enc_rdy;
  logic [DATA_WD-1:0] enc_data;

  modport master (output enc_vld, output enc_data, input enc_rdy);
  modport slave  (input enc_vld, input enc_data, output enc_rdy);
endinterface

// File: rtl/cmip_app_cnt.sv
// rtl/cmip_app_cnt.sv - free-running event counter with soft clear
module cmip_app_cnt #(
  parameter int WD = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [WD-1:0] o_cnt
);

  // Clear wins over increment; counter wraps at 2^WD
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      o_cnt <= '0;
    end else if (i_inc) begin
      o_cnt <= o_cnt + {{(WD-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/ddr_512b_enc_gen.sv
// rtl/ddr_512b_enc_gen.sv - burst/gap shaped counter-pattern generator (optional ENC_GEN_ERR_INJ_EN)
module ddr_512b_enc_gen
  import ddr_enc_pkg::*;
#(
  parameter int DATA_WD = 64,
  parameter int CNT_WD  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_rst,
  input  logic                cfg_start,
  input  logic                cfg_stop,
  input  logic [15:0]         cfg_burst_len,
  input  logic [15:0]         cfg_gap_len,
  input  logic [CNT_WD-1:0]   cfg_total,
  input  logic                cfg_err_inj,
  ddr_512b_enc_gen_if.master  enc,
  output logic                busy,
  output logic                done,
  output logic [CNT_WD-1:0]   tx_cnt
);

  localparam int FILL_WD  = DATA_WD - PKT_CNT_WD;
  localparam int FILL_REP = FILL_WD / 48 + 1;
  localparam logic [FILL_REP*48-1:0] FILL_ALL = {FILL_REP{FILL_PAT}};
  localparam logic [FILL_WD-1:0]     FILL     = FILL_ALL[FILL_WD-1:0];

  enc_state_e             state, state_n;
  logic                   clr;
  logic                   xfer, stall, load_cfg;
  logic [15:0]            burst_len_q, gap_len_q;
  logic [15:0]            burst_cnt, burst_cnt_n, gap_cnt, gap_cnt_n;
  logic [CNT_WD-1:0]      total_q, sent_cnt, sent_cnt_n;
  logic                   stop_pend, stop_pend_n;
  logic [PKT_CNT_WD-1:0]  pkt_cnt, pkt_cnt_n;
  logic [DATA_WD-1:0]     data_q;
  logic                   err_pend_n;

  assign clr   = rst | cfg_rst;
  assign xfer  = enc.enc_vld & enc.enc_rdy;
  assign stall = enc.enc_vld & ~enc.enc_rdy;

  assign enc.enc_vld  = (state == ST_SEND);
  assign enc.enc_data = data_q;
  assign busy         = (state == ST_SEND) || (state == ST_GAP);
  assign done         = (state == ST_DONE);
  assign pkt_cnt_n    = xfer ? pkt_cnt + 16'd1 : pkt_cnt;

  // Next-state and burst/gap/total bookkeeping
  always_comb begin
    state_n     = state;
    burst_cnt_n = burst_cnt;
    gap_cnt_n   = gap_cnt;
    sent_cnt_n  = sent_cnt;
    stop_pend_n = stop_pend;
    load_cfg    = 1'b0;
    case (state)
      ST_IDLE: begin
        // A simultaneous stop cancels the start
        if (cfg_start && !cfg_stop && cfg_burst_len != 16'd0) begin
          state_n     = ST_SEND;
          load_cfg    = 1'b1;
          sent_cnt_n  = '0;
          burst_cnt_n = 16'd0;
          gap_cnt_n   = 16'd0;
          stop_pend_n = 1'b0;
        end
      end
      ST_SEND: begin
        if (cfg_stop) stop_pend_n = 1'b1;
        if (xfer) begin
          sent_cnt_n  = sent_cnt + {{(CNT_WD-1){1'b0}}, 1'b1};
          burst_cnt_n = burst_cnt + 16'd1;
          if (total_q != '0 && sent_cnt_n == total_q) begin
            state_n = ST_DONE;
          end else if (stop_pend || cfg_stop) begin
            state_n = ST_DONE;
          end else if (burst_cnt_n == burst_len_q) begin
            burst_cnt_n = 16'd0;
            if (gap_len_q != 16'd0) state_n = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (cfg_stop) begin
          state_n = ST_DONE;
        end else if (gap_cnt == gap_len_q - 16'd1) begin
          gap_cnt_n = 16'd0;
          state_n   = ST_SEND;
        end else begin
          gap_cnt_n = gap_cnt + 16'd1;
        end
      end
      ST_DONE: begin
        state_n     = ST_IDLE;
        stop_pend_n = 1'b0;
        burst_cnt_n = 16'd0;
        gap_cnt_n   = 16'd0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, counters and latched configuration
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= ST_IDLE;
      burst_cnt   <= 16'd0;
      gap_cnt     <= 16'd0;
      sent_cnt    <= '0;
      stop_pend   <= 1'b0;
      pkt_cnt     <= '0;
      burst_len_q <= 16'd0;
      gap_len_q   <= 16'd0;
      total_q     <= '0;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_cnt_n;
      gap_cnt   <= gap_cnt_n;
      sent_cnt  <= sent_cnt_n;
      stop_pend <= stop_pend_n;
      pkt_cnt   <= pkt_cnt_n;
      if (load_cfg) begin
        burst_len_q <= cfg_burst_len;
        gap_len_q   <= cfg_gap_len;
        total_q     <= cfg_total;
      end
    end
  end

`ifdef ENC_GEN_ERR_INJ_EN
  logic err_pend;

  // One-shot arm; released when the corrupted word (bit 0 differs from pkt_cnt) transfers
  always_comb begin
    err_pend_n = err_pend;
    if (err_pend) begin
      if (xfer && (data_q[0] ^ pkt_cnt[0])) err_pend_n = 1'b0;
    end else begin
      err_pend_n = cfg_err_inj;
    end
  end

  // Error-injection flag register
  always_ff @(posedge clk) begin
    if (clr) err_pend <= 1'b0;
    else     err_pend <= err_pend_n;
  end
`else
  logic unused_err_inj;
  assign unused_err_inj = cfg_err_inj;
  assign err_pend_n     = 1'b0;
`endif

  // Output word: reloads whenever not stalled, so it is held while vld && !rdy
  always_ff @(posedge clk) begin
    if (clr) begin
      data_q <= '0;
    end else if (!stall) begin
      data_q <= {FILL, pkt_cnt_n[PKT_CNT_WD-1:1], pkt_cnt_n[0] ^ err_pend_n};
    end
  end

  cmip_app_cnt #(.WD(CNT_WD)) u_tx_cnt (
    .clk   (clk),
    .rst_n (~rst),
    .i_clr (cfg_rst),
    .i_inc (xfer),
    .o_cnt (tx_cnt)
  );

endmodule

// File: tb/tb_ddr_512b_enc_gen.sv
// tb/tb_ddr_512b_enc_gen.sv - self-checking bench for ddr_512b_enc_gen
module tb_ddr_512b_enc_gen;

  localparam int DATA_WD = 64;
  localparam int CNT_WD  = 32;
  localparam logic [47:0] FILL = 48'hBBBB_CCCC_DDDD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, cfg_rst = 1'b0, cfg_start = 1'b0, cfg_stop = 1'b0, cfg_err_inj = 1'b0;
  logic [15:0]       cfg_burst_len = 16'd0, cfg_gap_len = 16'd0;
  logic [CNT_WD-1:0] cfg_total = '0;
  logic              busy, done;
  logic [CNT_WD-1:0] tx_cnt;
  logic              rdy = 1'b1;

  ddr_512b_enc_gen_if #(.DATA_WD(DATA_WD)) enc_if ();
  assign enc_if.enc_rdy = rdy;

  ddr_512b_enc_gen #(.DATA_WD(DATA_WD), .CNT_WD(CNT_WD)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_rst       (cfg_rst),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .cfg_burst_len (cfg_burst_len),
    .cfg_gap_len   (cfg_gap_len),
    .cfg_total     (cfg_total),
    .cfg_err_inj   (cfg_err_inj),
    .enc           (enc_if),
    .busy          (busy),
    .done          (done),
    .tx_cnt        (tx_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model state: expected next counter value and shaping observations
  logic [15:0] exp_pkt = 16'd0, last_low = 16'd0;
  int          n_xfer = 0, run_xfer = 0, low_run = 0, n_done = 0;
  int          suc_cnt = 0, err_cnt = 0, err_idx = -1;
  logic [63:0] err_diff = '0, prev_data = '0, expw;
  bit          prev_stall = 0, wrap_seen = 0, err_mode = 0;
  int          cur_b = 1, cur_g = 0;

  // Monitor: sampled on the falling edge, models what the next rising edge does
  always @(negedge clk) begin
    if (rst || cfg_rst) begin
      exp_pkt = 16'd0; n_xfer = 0; run_xfer = 0; low_run = 0; prev_stall = 0;
    end else begin
      expw = {FILL, exp_pkt};
      if (prev_stall) begin
        chk("hold_vld", enc_if.enc_vld, 1);
        chk("hold_data", enc_if.enc_data, prev_data);
      end
      if (done) begin
        n_done++; run_xfer = 0; low_run = 0;
      end else if (enc_if.enc_vld) begin
        if (low_run > 0)
          chk("gap_len", low_run, (cur_b != 0 && run_xfer % cur_b == 0) ? cur_g : 0);
        low_run = 0;
      end else if (busy && run_xfer > 0) begin
        low_run++;
      end
      if (enc_if.enc_vld && rdy) begin
        if (err_mode) begin
          if (enc_if.enc_data == expw) suc_cnt++;
          else begin err_cnt++; err_idx = run_xfer; err_diff = enc_if.enc_data ^ expw; end
        end else begin
          chk("word", enc_if.enc_data, expw);
        end
        if (n_xfer > 0 && last_low == 16'hFFFF && enc_if.enc_data[15:0] == 16'h0000) wrap_seen = 1;
        last_low = enc_if.enc_data[15:0];
        exp_pkt++; n_xfer++; run_xfer++;
      end
      prev_stall = enc_if.enc_vld && !rdy;
      prev_data  = enc_if.enc_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_vld"},  enc_if.enc_vld, 0);
    chk({tag, "_data"}, enc_if.enc_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_tx"},   tx_cnt, 0);
  endtask

  task automatic soft_clear();
    cfg_rst = 1'b1; step(); chk_cleared("softclr"); cfg_rst = 1'b0;
  endtask

  task automatic start_run(input int b, input int g, input int t);
    cur_b = b; cur_g = g;
    cfg_burst_len = b[15:0]; cfg_gap_len = g[15:0]; cfg_total = t;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
  endtask

  // mode 0: rdy held, 1: random rdy, 2: toggling rdy + stop after 5 transfers, 3: err_inj while word 2 is presented
  task automatic run_until_done(input int mode, input int budget, output int cyc);
    bit fired = 0;
    cyc = 1;
    while (!done && cyc < budget) begin
      case (mode)
        1: rdy = 1'($urandom_range(0, 1));
        2: begin
          rdy = ~rdy;
          cfg_stop = (n_xfer == 5 && !fired);
          if (cfg_stop) fired = 1;
        end
        3: begin
          cfg_err_inj = (n_xfer == 2 && !fired);
          if (cfg_err_inj) fired = 1;
        end
        default: ;
      endcase
      step(); cyc++;
    end
    cfg_stop = 1'b0; cfg_err_inj = 1'b0;
    chk("done_seen", done, 1);
  endtask

  typedef struct {
    int b; int g; int t; bit rnd; int exp_done_cyc; int exp_tx;
  } vec_t;

  vec_t rows[10];
  int   cyc, d0;

  initial begin
    rows[0] = '{4, 2, 10, 0, 15, 10};
    rows[1] = '{3, 0, 7,  0, 8,  7};
    rows[2] = '{1, 1, 3,  0, 6,  3};
    rows[3] = '{5, 3, 5,  0, 6,  5};
    rows[4] = '{2, 4, 5,  0, 14, 5};
    rows[5] = '{6, 1, 13, 0, 16, 13};
    for (int i = 6; i < 10; i++) begin
      rows[i].b = int'($urandom_range(1, 6));
      rows[i].g = int'($urandom_range(0, 4));
      rows[i].t = int'($urandom_range(1, 30));
      rows[i].rnd = 1;
      rows[i].exp_done_cyc = 0;
      rows[i].exp_tx = rows[i].t;
    end

    step(); step();
    chk_cleared("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      soft_clear();
      rdy = 1'b1;
      d0 = n_done;
      start_run(rows[i].b, rows[i].g, rows[i].t);
      chk("start_latency", enc_if.enc_vld, 1);
      run_until_done(rows[i].rnd ? 1 : 0, 3000, cyc);
      if (rows[i].exp_done_cyc != 0) chk("done_cycle", cyc, rows[i].exp_done_cyc);
      chk("tx_cnt", tx_cnt, rows[i].exp_tx);
      step();
      chk("done_once", n_done, d0 + 1);
      chk("idle_vld", enc_if.enc_vld, 0);
      chk("idle_busy", busy, 0);
    end

    // Graceful stop with toggling backpressure
    soft_clear();
    rdy = 1'b1;
    start_run(8, 0, 0);
    run_until_done(2, 300, cyc);
    chk("stop_tx", tx_cnt, 6);
    chk("stop_model_xfer", n_xfer, 6);

    // Soft clear while a word is stalled, then restart from packet 0
    soft_clear();
    rdy = 1'b1;
    start_run(8, 0, 0);
    step(); step();
    rdy = 1'b0;
    step();
    chk("stall_vld", enc_if.enc_vld, 1);
    cfg_rst = 1'b1; step(); cfg_rst = 1'b0;
    chk("midclr_vld", enc_if.enc_vld, 0);
    chk("midclr_tx", tx_cnt, 0);
    chk("midclr_busy", busy, 0);
    rdy = 1'b1;
    start_run(2, 0, 3);
    chk("restart_word", enc_if.enc_data, {FILL, 16'h0000});
    run_until_done(0, 100, cyc);
    chk("restart_tx", tx_cnt, 3);
    step();

    // Zero burst length rejects the start
    start_run(0, 2, 5);
    for (int k = 0; k < 4; k++) begin
      chk("burst0_vld", enc_if.enc_vld, 0);
      chk("burst0_busy", busy, 0);
      step();
    end

    // Start and stop together: stop wins
    cur_b = 4; cfg_burst_len = 16'd4; cfg_total = 5;
    cfg_start = 1'b1; cfg_stop = 1'b1; step(); cfg_start = 1'b0; cfg_stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("startstop_vld", enc_if.enc_vld, 0);
      chk("startstop_busy", busy, 0);
      step();
    end

    // Error injection on the word after word 2
    soft_clear();
    rdy = 1'b1;
    err_mode = 1;
    start_run(4, 2, 10);
    run_until_done(3, 100, cyc);
    step();
    err_mode = 0;
`ifdef ENC_GEN_ERR_INJ_EN
    chk("inj_suc", suc_cnt, 9);
    chk("inj_err", err_cnt, 1);
    chk("inj_idx", err_idx, 3);
    chk("inj_bit", err_diff, 64'h1);
`else
    chk("inj_suc", suc_cnt, 10);
    chk("inj_err", err_cnt, 0);
`endif

    // Counter wrap over a long continuous run
    soft_clear();
    rdy = 1'b1;
    start_run(16, 0, 70000);
    run_until_done(0, 71000, cyc);
    chk("wrap_tx", tx_cnt, 70000);
    chk("wrap_seen", wrap_seen, 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
